hash_test_ctrl: RTL



---
 rtl/hash_test_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hash_test_ctrl.sv
// On-chip test-flow controller for a block-hash core: LFSR message blocks, init/next sequencing,
// MISR signature of returned digests, timeout flagging. Define CONTINUOUS_RUN_EN for endless runs.
module hash_test_ctrl #(
    parameter int          BLOCK_W     = 512,
    parameter int          DIGEST_W    = 256,
    parameter int          NUM_VECTORS = 16,
    parameter int          TIMEOUT_CYC = 30,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               core_ready,
    input  logic                               digest_valid,
    input  logic [DIGEST_W-1:0]                digest,
    output logic                               init,
    output logic                               next,
    output logic [BLOCK_W-1:0]                 block,
    output logic                               busy,
    output logic                               done,
    output logic [DIGEST_W-1:0]                signature,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count,
    output logic                               timeout_err
);

    localparam int          LANES = BLOCK_W / 32;
    localparam int          VCW   = $clog2(NUM_VECTORS + 1);
    localparam int          TCW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] POLY  = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_INIT,
        S_NEXT,
        S_WAIT_DIGEST,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             init_d;
    logic             next_d;
    logic             done_d;
    logic [TCW-1:0]   tcnt;
    logic [TCW-1:0]   tcnt_inc;
    logic             wait_to;
    logic [VCW-1:0]   vec_inc;
    logic             last_vec;

    function automatic logic [BLOCK_W-1:0] seed_pattern();
        logic [BLOCK_W-1:0] p;
        logic [31:0]        lane;
        p = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = SEED ^ 32'(i);
            if (lane == 32'h0) lane = 32'h1;
            p[32*i +: 32] = lane;
        end
        return p;
    endfunction

    function automatic logic [BLOCK_W-1:0] lfsr_step(input logic [BLOCK_W-1:0] cur);
        logic [BLOCK_W-1:0] nx;
        logic [31:0]        s;
        nx = '0;
        for (int i = 0; i < LANES; i++) begin
            s = cur[32*i +: 32];
            nx[32*i +: 32] = (s >> 1) ^ (s[0] ? POLY : 32'h0);
        end
        return nx;
    endfunction

    // Core handshake: a command is issued only after core_ready is seen high (or the wait times
    // out); a digest is consumed in the single cycle digest_valid is high during WAIT_DIGEST and
    // ignored in every other state. The core never sees backpressure from this block.

    assign tcnt_inc = (tcnt == TCW'(TIMEOUT_CYC)) ? tcnt : tcnt + TCW'(1);
    assign wait_to  = (tcnt == TCW'(TIMEOUT_CYC - 1));
    assign vec_inc  = vec_count + VCW'(1);
    assign last_vec = (vec_inc == VCW'(NUM_VECTORS));
    assign busy     = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            init  <= 1'b0;
            next  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            init  <= init_d;
            next  <= next_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_WAIT_READY;
            S_WAIT_READY:   if (core_ready || wait_to) state_nx = S_INIT;
            S_INIT:         state_nx = S_NEXT;
            S_NEXT:         state_nx = S_WAIT_DIGEST;
            S_WAIT_DIGEST:  if (digest_valid || wait_to) state_nx = S_CAPTURE;
            S_CAPTURE: begin
`ifdef CONTINUOUS_RUN_EN
                state_nx = S_WAIT_READY;
`else
                state_nx = last_vec ? S_DONE : S_WAIT_READY;
`endif
            end
            default:        state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    // Strobes are registered from the next state so each is high for exactly the INIT/NEXT cycle.
    always_comb begin
        init_d = (state_nx == S_INIT);
        next_d = (state_nx == S_NEXT);
        done_d = (state == S_CAPTURE) && last_vec && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signature   <= '0;
            vec_count   <= '0;
            timeout_err <= 1'b0;
            tcnt        <= '0;
            block       <= seed_pattern();
        end else if (!abort) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        signature   <= '0;
                        vec_count   <= '0;
                        timeout_err <= 1'b0;
                        tcnt        <= '0;
                        block       <= seed_pattern();
                    end
                end
                S_WAIT_READY: begin
                    if (!core_ready) begin
                        tcnt <= tcnt_inc;
                        if (wait_to) timeout_err <= 1'b1;
                    end
                end
                S_NEXT: tcnt <= '0;
                S_WAIT_DIGEST: begin
                    if (digest_valid) begin
                        signature <= {signature[DIGEST_W-2:0], signature[DIGEST_W-1]} ^ digest;
                    end else begin
                        tcnt <= tcnt_inc;
                        if (wait_to) timeout_err <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    block <= lfsr_step(block);
                    tcnt  <= '0;
`ifdef CONTINUOUS_RUN_EN
                    vec_count <= last_vec ? '0 : vec_inc;
`else
                    vec_count <= vec_inc;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
